// File: rtl/regfile_write_queue_pkg.sv
// Shared processor parameters for the register file and its write queue.
package regfile_write_queue_pkg;

   localparam int RF_DATA_W   = 16;
   localparam int RF_ADDR_W   = 4;
   localparam int RF_WQ_DEPTH = 4;

endpackage

// File: rtl/regfile_write_queue_fifo.sv
// Two-push, one-pop circular buffer of {reg, data} entries for the write queue.
module wq_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 20
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        i_push0,
   input  logic [W-1:0]                i_data0,
   input  logic                        i_push1,
   input  logic [W-1:0]                i_data1,
   input  logic                        i_pop,
   output logic [W-1:0]                o_head,
   output logic [$clog2(DEPTH):0]      o_count,
   output logic [DEPTH-1:0]            o_slot_vld,
   output logic [DEPTH-1:0][W-1:0]     o_slots
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [W-1:0]  r_mem [DEPTH];
   logic [PW-1:0] r_wptr;
   logic [PW-1:0] r_rptr;
   logic [CW-1:0] r_count;
   logic [PW-1:0] w_wptr1;
   logic          w_pop;

   // Port 1 lands behind port 0 when both push, keeping port-0 data older.
   assign w_wptr1 = r_wptr + PW'(i_push0);
   assign w_pop   = i_pop && (r_count != '0);

   always_ff @(posedge clk) begin
      if (i_push0) r_mem[r_wptr]  <= i_data0;
      if (i_push1) r_mem[w_wptr1] <= i_data1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         r_wptr  <= r_wptr + PW'(i_push0) + PW'(i_push1);
         r_rptr  <= r_rptr + PW'(w_pop);
         r_count <= r_count + CW'(i_push0) + CW'(i_push1) - CW'(w_pop);
      end
   end

   assign o_head  = r_mem[r_rptr];
   assign o_count = r_count;

   // A slot is live when its distance from the read pointer is below occupancy.
   for (genvar g = 0; g < DEPTH; g++) begin : g_slot
      logic [PW-1:0] w_off;
      assign w_off         = PW'(g) - r_rptr;
      assign o_slot_vld[g] = CW'(w_off) < r_count;
      assign o_slots[g]    = r_mem[g];
   end

endmodule

// File: rtl/regfile_write_queue.sv
// Merges load and ALU results into one register-file write port; loads win the last free slot.
module regfile_write_queue
   import regfile_write_queue_pkg::*;
#(
   parameter int DEPTH  = RF_WQ_DEPTH,
   parameter int DATA_W = RF_DATA_W,
   parameter int ADDR_W = RF_ADDR_W
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     mem_valid,
   output logic                     mem_ready,
   input  logic [ADDR_W-1:0]        mem_reg,
   input  logic [DATA_W-1:0]        mem_data,
   input  logic                     alu_valid,
   output logic                     alu_ready,
   input  logic [ADDR_W-1:0]        alu_reg,
   input  logic [DATA_W-1:0]        alu_data,
   output logic                     WriteReg,
   output logic [ADDR_W-1:0]        DstReg,
   output logic [DATA_W-1:0]        DstData,
   output logic [(1<<ADDR_W)-1:0]   pending_mask,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int CW   = $clog2(DEPTH) + 1;
   localparam int EW   = ADDR_W + DATA_W;
   localparam int NREG = 1 << ADDR_W;

   logic [CW-1:0]            w_count;
   logic [CW-1:0]            w_free;
   logic                     w_mem_push;
   logic                     w_alu_push;
   logic [EW-1:0]            w_head;
   logic [DEPTH-1:0]         w_slot_vld;
   logic [DEPTH-1:0][EW-1:0] w_slots;

   assign w_free = CW'(DEPTH) - w_count;

   // Readies look only at start-of-cycle occupancy, so a full queue stalls
   // both sources for the cycle even though its head drains.
   always_comb begin
      mem_ready = 1'b0;
      alu_ready = 1'b0;
      if (!rst) begin
         if (w_free >= CW'(2)) begin
            mem_ready = 1'b1;
            alu_ready = 1'b1;
         end else if (w_free == CW'(1)) begin
            mem_ready = 1'b1;
            alu_ready = !mem_valid;
         end
      end
   end

   assign w_mem_push = mem_valid && mem_ready;
   assign w_alu_push = alu_valid && alu_ready;

   wq_fifo #(.DEPTH(DEPTH), .W(EW)) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .i_push0    (w_mem_push),
      .i_data0    ({mem_reg, mem_data}),
      .i_push1    (w_alu_push),
      .i_data1    ({alu_reg, alu_data}),
      .i_pop      (WriteReg),
      .o_head     (w_head),
      .o_count    (w_count),
      .o_slot_vld (w_slot_vld),
      .o_slots    (w_slots)
   );

   assign count    = w_count;
   assign empty    = (w_count == '0);
   assign full     = (w_count == CW'(DEPTH));
   assign WriteReg = !empty;
   assign DstReg   = empty ? '0 : w_head[EW-1:DATA_W];
   assign DstData  = empty ? '0 : w_head[DATA_W-1:0];

   always_comb begin
      pending_mask = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (w_slot_vld[i]) pending_mask[w_slots[i][EW-1:DATA_W]] = 1'b1;
      end
   end

   logic [NREG-1:0] w_unused_chk;
   assign w_unused_chk = pending_mask;

endmodule

// File: tb/tb_regfile_write_queue.sv
// Directed vector bench for regfile_write_queue (4-deep main instance, 2-deep full-boundary instance).
module tb_regfile_write_queue;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic        mv, av, mrdy, ardy, wr, full, empty;
   logic [3:0]  mr, ar, dreg;
   logic [15:0] md, ad, ddata, mask;
   logic [2:0]  cnt;

   logic        d2_mv, d2_av, d2_mrdy, d2_ardy, d2_wr, d2_full, d2_empty;
   logic [3:0]  d2_mr, d2_ar, d2_dreg;
   logic [15:0] d2_md, d2_ad, d2_ddata, d2_mask;
   logic [1:0]  d2_cnt;

   regfile_write_queue dut (
      .clk(clk), .rst(rst),
      .mem_valid(mv), .mem_ready(mrdy), .mem_reg(mr), .mem_data(md),
      .alu_valid(av), .alu_ready(ardy), .alu_reg(ar), .alu_data(ad),
      .WriteReg(wr), .DstReg(dreg), .DstData(ddata), .pending_mask(mask),
      .count(cnt), .full(full), .empty(empty)
   );

   // With continuous drain a 4-deep queue never fills, so full is exercised at depth 2.
   regfile_write_queue #(.DEPTH(2)) dut2 (
      .clk(clk), .rst(rst),
      .mem_valid(d2_mv), .mem_ready(d2_mrdy), .mem_reg(d2_mr), .mem_data(d2_md),
      .alu_valid(d2_av), .alu_ready(d2_ardy), .alu_reg(d2_ar), .alu_data(d2_ad),
      .WriteReg(d2_wr), .DstReg(d2_dreg), .DstData(d2_ddata), .pending_mask(d2_mask),
      .count(d2_cnt), .full(d2_full), .empty(d2_empty)
   );

   typedef struct {
      logic        rst;
      logic        mv;
      logic [3:0]  mr;
      logic [15:0] md;
      logic        av;
      logic [3:0]  ar;
      logic [15:0] ad;
      logic        e_mrdy;
      logic        e_ardy;
      logic        e_wr;
      logic [3:0]  e_reg;
      logic [15:0] e_data;
      logic [2:0]  e_cnt;
      logic [15:0] e_mask;
   } vec_t;

   vec_t tbl[14];
   int   n_tests = 0;
   int   n_fail  = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic m_v, input logic [3:0] m_r, input logic [15:0] m_d,
                        input logic a_v, input logic [3:0] a_r, input logic [15:0] a_d);
      mv = m_v; mr = m_r; md = m_d;
      av = a_v; ar = a_r; ad = a_d;
   endtask

   task automatic drive2(input logic m_v, input logic [3:0] m_r, input logic [15:0] m_d,
                         input logic a_v, input logic [3:0] a_r, input logic [15:0] a_d);
      d2_mv = m_v; d2_mr = m_r; d2_md = m_d;
      d2_av = a_v; d2_ar = a_r; d2_ad = a_d;
   endtask

   initial begin
      //           rst  mv   mr     md        av   ar     ad         mrdy ardy wr   reg    data      cnt   mask
      tbl[0]  = '{1'b1,1'b0,4'd0,16'h0000,1'b0,4'd0,16'h0000,  1'b0,1'b0,1'b0,4'd0,16'h0000,3'd0,16'h0000};
      tbl[1]  = '{1'b0,1'b1,4'd3,16'h1234,1'b0,4'd0,16'h0000,  1'b1,1'b1,1'b0,4'd0,16'h0000,3'd0,16'h0000};
      tbl[2]  = '{1'b0,1'b0,4'd0,16'h0000,1'b0,4'd0,16'h0000,  1'b1,1'b1,1'b1,4'd3,16'h1234,3'd1,16'h0008};
      tbl[3]  = '{1'b0,1'b1,4'd5,16'hAAAA,1'b1,4'd5,16'h5555,  1'b1,1'b1,1'b0,4'd0,16'h0000,3'd0,16'h0000};
      tbl[4]  = '{1'b0,1'b0,4'd0,16'h0000,1'b0,4'd0,16'h0000,  1'b1,1'b1,1'b1,4'd5,16'hAAAA,3'd2,16'h0020};
      tbl[5]  = '{1'b0,1'b0,4'd0,16'h0000,1'b0,4'd0,16'h0000,  1'b1,1'b1,1'b1,4'd5,16'h5555,3'd1,16'h0020};
      tbl[6]  = '{1'b0,1'b1,4'd1,16'h0101,1'b1,4'd2,16'h0202,  1'b1,1'b1,1'b0,4'd0,16'h0000,3'd0,16'h0000};
      tbl[7]  = '{1'b0,1'b1,4'd3,16'h0303,1'b1,4'd4,16'h0404,  1'b1,1'b1,1'b1,4'd1,16'h0101,3'd2,16'h0006};
      tbl[8]  = '{1'b0,1'b1,4'd6,16'h0606,1'b1,4'd7,16'h0707,  1'b1,1'b0,1'b1,4'd2,16'h0202,3'd3,16'h001C};
      tbl[9]  = '{1'b0,1'b0,4'd0,16'h0000,1'b1,4'd7,16'h0707,  1'b1,1'b1,1'b1,4'd3,16'h0303,3'd3,16'h0058};
      tbl[10] = '{1'b0,1'b0,4'd0,16'h0000,1'b0,4'd0,16'h0000,  1'b1,1'b1,1'b1,4'd4,16'h0404,3'd3,16'h00D0};
      tbl[11] = '{1'b0,1'b0,4'd0,16'h0000,1'b0,4'd0,16'h0000,  1'b1,1'b1,1'b1,4'd6,16'h0606,3'd2,16'h00C0};
      tbl[12] = '{1'b0,1'b0,4'd0,16'h0000,1'b0,4'd0,16'h0000,  1'b1,1'b1,1'b1,4'd7,16'h0707,3'd1,16'h0080};
      tbl[13] = '{1'b0,1'b0,4'd0,16'h0000,1'b0,4'd0,16'h0000,  1'b1,1'b1,1'b0,4'd0,16'h0000,3'd0,16'h0000};

      drive(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0);
      drive2(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0);

      // Table: inputs applied on the falling edge, outputs sampled 1 time unit later.
      for (int i = 0; i < 14; i++) begin
         @(negedge clk);
         rst = tbl[i].rst;
         drive(tbl[i].mv, tbl[i].mr, tbl[i].md, tbl[i].av, tbl[i].ar, tbl[i].ad);
         #1;
         chk($sformatf("row%0d mem_ready", i), 32'(mrdy),  32'(tbl[i].e_mrdy));
         chk($sformatf("row%0d alu_ready", i), 32'(ardy),  32'(tbl[i].e_ardy));
         chk($sformatf("row%0d WriteReg", i),  32'(wr),    32'(tbl[i].e_wr));
         chk($sformatf("row%0d DstReg", i),    32'(dreg),  32'(tbl[i].e_reg));
         chk($sformatf("row%0d DstData", i),   32'(ddata), 32'(tbl[i].e_data));
         chk($sformatf("row%0d count", i),     32'(cnt),   32'(tbl[i].e_cnt));
         chk($sformatf("row%0d pending", i),   32'(mask),  32'(tbl[i].e_mask));
         chk($sformatf("row%0d full", i),      32'(full),  32'(tbl[i].e_cnt == 3'd4));
         chk($sformatf("row%0d empty", i),     32'(empty), 32'(tbl[i].e_cnt == 3'd0));
      end

      // Wrap: 10 single pushes alternating ports, drained every cycle.
      for (int i = 0; i <= 10; i++) begin
         logic [3:0]  r;
         logic [15:0] d;
         @(negedge clk);
         r = 4'(i);
         d = 16'hC000 + 16'(i);
         if (i == 10)     drive(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0);
         else if (i[0])   drive(1'b0, 4'd0, 16'h0, 1'b1, r, d);
         else             drive(1'b1, r, d, 1'b0, 4'd0, 16'h0);
         #1;
         chk($sformatf("wrap%0d count", i), 32'(cnt), (i == 0) ? 32'd0 : 32'd1);
         if (i > 0) begin
            chk($sformatf("wrap%0d WriteReg", i), 32'(wr),    32'd1);
            chk($sformatf("wrap%0d DstReg", i),   32'(dreg),  32'(i - 1));
            chk($sformatf("wrap%0d DstData", i),  32'(ddata), 32'h0000C000 + 32'(i - 1));
         end
      end
      @(negedge clk);
      #1;
      chk("wrap drained", 32'(empty), 32'd1);

      // Full boundary on the 2-deep instance.
      @(negedge clk);
      drive2(1'b1, 4'd1, 16'h0011, 1'b1, 4'd2, 16'h0022);
      #1;
      chk("d2 empty mem_ready", 32'(d2_mrdy), 32'd1);
      chk("d2 empty alu_ready", 32'(d2_ardy), 32'd1);
      @(negedge clk);
      drive2(1'b1, 4'd3, 16'h0033, 1'b1, 4'd4, 16'h0044);
      #1;
      chk("d2 full flag",      32'(d2_full), 32'd1);
      chk("d2 full count",     32'(d2_cnt),  32'd2);
      chk("d2 full mem_ready", 32'(d2_mrdy), 32'd0);
      chk("d2 full alu_ready", 32'(d2_ardy), 32'd0);
      chk("d2 full WriteReg",  32'(d2_wr),   32'd1);
      chk("d2 full DstData",   32'(d2_ddata), 32'h0011);
      chk("d2 full pending",   32'(d2_mask), 32'h0006);
      @(negedge clk);
      #1;
      chk("d2 after count",     32'(d2_cnt),   32'd1);
      chk("d2 after full",      32'(d2_full),  32'd0);
      chk("d2 after mem_ready", 32'(d2_mrdy),  32'd1);
      chk("d2 after alu_ready", 32'(d2_ardy),  32'd0);
      chk("d2 after DstData",   32'(d2_ddata), 32'h0022);
      @(negedge clk);
      drive2(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0);
      #1;
      chk("d2 mem accepted DstReg",  32'(d2_dreg),  32'd3);
      chk("d2 mem accepted DstData", 32'(d2_ddata), 32'h0033);
      chk("d2 alu dropped count",    32'(d2_cnt),   32'd1);
      @(negedge clk);
      #1;
      chk("d2 drained", 32'(d2_empty), 32'd1);

      // Reset with three entries queued.
      @(negedge clk);
      drive(1'b1, 4'd1, 16'h0A01, 1'b1, 4'd2, 16'h0A02);
      @(negedge clk);
      drive(1'b1, 4'd3, 16'h0A03, 1'b1, 4'd4, 16'h0A04);
      @(negedge clk);
      drive(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0);
      #1;
      chk("rst pre count", 32'(cnt), 32'd3);
      #1 rst = 1'b1;
      #1;
      chk("rst WriteReg",  32'(wr),    32'd0);
      chk("rst count",     32'(cnt),   32'd0);
      chk("rst pending",   32'(mask),  32'd0);
      chk("rst DstData",   32'(ddata), 32'd0);
      chk("rst mem_ready", 32'(mrdy),  32'd0);
      chk("rst alu_ready", 32'(ardy),  32'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("post-rst mem_ready", 32'(mrdy), 32'd1);
      chk("post-rst alu_ready", 32'(ardy), 32'd1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         #1;
         chk($sformatf("post-rst%0d WriteReg", i), 32'(wr),  32'd0);
         chk($sformatf("post-rst%0d count", i),    32'(cnt), 32'd0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/regfile_write_queue.md
REGFILE_WRITE_QUEUE -- requirements
Module: regfile_write_queue

Interface
REQ-001 Parameter DEPTH, default 4, meaning queue entries; power of two, at least 2.
REQ-002 Parameter DATA_W, default 16, meaning register data width.
REQ-003 Parameter ADDR_W, default 4, meaning register index width (16 registers).
REQ-004 clk  input  1  sole clock; all state on its rising edge.
REQ-005 rst  input  1  reset; asynchronous, active-high.
REQ-006 mem_valid  input  1  load-result write request.
REQ-007 mem_ready  output  1  load request accepted this cycle when high with mem_valid.
REQ-008 mem_reg  input  ADDR_W  load destination register.
REQ-009 mem_data  input  DATA_W  load write data.
REQ-010 alu_valid  input  1  ALU-result write request.
REQ-011 alu_ready  output  1  ALU request accepted this cycle when high with alu_valid.
REQ-012 alu_reg  input  ADDR_W  ALU destination register.
REQ-013 alu_data  input  DATA_W  ALU write data.
REQ-014 WriteReg  output  1  register-file write strobe.
REQ-015 DstReg  output  ADDR_W  register-file write index.
REQ-016 DstData  output  DATA_W  register-file write data.
REQ-017 pending_mask  output  2**ADDR_W  bit i high while any queued entry targets register i.
REQ-018 count  output  clog2(DEPTH)+1  current occupancy.
REQ-019 full, empty  output  1 each  count==DEPTH, count==0.

Function
REQ-020 The block SHALL be a FIFO of {reg, data} entries; the head drains to the register-file write port, one entry per cycle, with no backpressure from the register file.
REQ-021 WriteReg SHALL equal !empty; DstReg/DstData SHALL present the head entry, and 0 when empty.
REQ-022 Head pops on a rising edge where WriteReg=1.
REQ-023 Readies SHALL derive from occupancy at cycle start only, never from same-cycle pop: free = DEPTH-count.
REQ-024 free>=2: mem_ready=1, alu_ready=1.
REQ-025 free==1: mem_ready=1; alu_ready = !mem_valid (load has priority).
REQ-026 free==0: both readies 0, even though a pop occurs that cycle.
REQ-027 Both accepted same cycle: mem entry SHALL be enqueued ahead of alu entry.
REQ-028 Next count = count + accepted pushes - pop; simultaneous push and pop at any occupancy SHALL be consistent, with no loss or duplication.
REQ-029 Read/write pointers SHALL wrap modulo DEPTH.
REQ-030 No combinational path from request inputs to WriteReg/DstReg/DstData; minimum latency is one cycle (accepted at edge N, WriteReg high in the cycle after edge N).
REQ-031 Writes to the same register SHALL reach the register file in acceptance order.
REQ-032 pending_mask SHALL be combinational from valid storage entries; it includes the head entry until it pops.

Reset
REQ-033 While rst=1: pointers=0, count=0, empty=1, full=0, WriteReg=0, DstReg=0, DstData=0, pending_mask=0, mem_ready=0, alu_ready=0.
REQ-034 Reset mid-operation SHALL discard all queued entries without a WriteReg pulse; storage array needs no reset.
REQ-035 First cycle after rst deasserts: both readies 1.

Structure
REQ-036 DATA_W, ADDR_W, and the default DEPTH SHALL live in the shared processor package used by the register file.
REQ-037 Storage and pointers SHALL be one sub-module, wq_fifo (2 push ports, 1 pop port); arbitration and pending_mask stay in regfile_write_queue.

Verification
REQ-038 Single push: mem push R3=0x1234 at edge 0 -> WriteReg=1, DstReg=3, DstData=0x1234 in cycle 1, empty in cycle 2.
REQ-039 Dual push: mem R5=0xAAAA and alu R5=0x5555 same cycle -> R5 writes in the order 0xAAAA then 0x5555; pending_mask[5] stays high across both and clears after the second pop.
REQ-040 Priority at free==1: count=3 with both valid -> mem accepted, alu_ready=0; alu accepted next cycle.
REQ-041 Full: fill to 4 -> full=1 and both readies 0 despite a concurrent pop; readies return the next cycle with count=3.
REQ-042 Wrap: 10 consecutive single pushes with continuous drain -> the 10 writes appear in order, count never exceeds 1.
REQ-043 Reset: rst pulses with 3 entries queued -> WriteReg drops immediately, no further writes, count=0, pending_mask=0.
